// File: rtl/push_button_pkg.sv
// Shared types and constants for the push-button conditioner.
package push_button_pkg;

   typedef enum logic [1:0] {REL, WAIT_PRS, PRS, WAIT_REL} btn_state_t;

   localparam logic [7:0] PRESS_CNT_MAX = 8'd255;

   function automatic int cnt_w_f(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce FSM, edge pulses, sticky flag.
// Optional 8-bit saturating press counter when BTN_PRESS_COUNT_EN is defined.
module btn_debounce_ch
   import push_button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       key_raw_ni,
   input  logic       sticky_clr_i,
   output logic       level_no,
   output logic       press_o,
   output logic       release_o,
   output logic       sticky_o,
   output logic [7:0] count_o
);

   localparam int CNT_W = cnt_w_f(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync2_q;
   btn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             sticky_q, sticky_d;
   logic             s_n;

   assign s_n = sync2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync1_q   <= 1'b1;
         sync2_q   <= 1'b1;
         state_q   <= REL;
         cnt_q     <= '0;
         level_q   <= 1'b1;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         sync1_q   <= key_raw_ni;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         sticky_q  <= sticky_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         REL: begin
            if (!s_n) begin
               state_d = WAIT_PRS;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT_PRS: begin
            if (s_n) begin
               state_d = REL;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRS;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         PRS: begin
            if (s_n) begin
               state_d = WAIT_REL;
               cnt_d   = CNT_W'(1);
            end else begin
               cnt_d   = '0;
            end
         end
         WAIT_REL: begin
            if (!s_n) begin
               state_d = PRS;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = REL;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = REL;
            cnt_d   = '0;
         end
      endcase

      level_d   = !((state_d == PRS) || (state_d == WAIT_REL));
      press_d   = level_q & ~level_d;
      release_d = ~level_q & level_d;
      // press_q keeps the flag set when a clear lands in the cycle the press pulse is visible.
      sticky_d  = press_d | press_q | (sticky_q & ~sticky_clr_i);
   end

   assign level_no  = level_q;
   assign press_o   = press_q;
   assign release_o = release_q;
   assign sticky_o  = sticky_q;

`ifdef BTN_PRESS_COUNT_EN
   logic [7:0] pcnt_q, pcnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

   // A clear coinciding with a press (pending or just shown) leaves a count of one.
   always_comb begin
      pcnt_d = pcnt_q;
      if (sticky_clr_i) begin
         pcnt_d = (press_d | press_q) ? 8'd1 : 8'd0;
      end else if (press_d && (pcnt_q != PRESS_CNT_MAX)) begin
         pcnt_d = pcnt_q + 8'd1;
      end
   end

   assign count_o = pcnt_q;
`else
   assign count_o = '0;
`endif

endmodule

// File: rtl/push_button_conditioner.sv
// Debounces NUM_BTN active-low board keys for the soc_system PIO and fabric logic.
// Define BTN_PRESS_COUNT_EN to build the per-button saturating press counters.
module push_button_conditioner
   import push_button_pkg::*;
#(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                 clk_clk,
   input  logic                 reset_reset_n,
   input  logic [NUM_BTN-1:0]   key_raw_n,
   output logic [NUM_BTN-1:0]   btn_level_n,
   output logic [NUM_BTN-1:0]   btn_press,
   output logic [NUM_BTN-1:0]   btn_release,
   output logic [NUM_BTN-1:0]   press_sticky,
   input  logic [NUM_BTN-1:0]   sticky_clr,
   output logic [8*NUM_BTN-1:0] press_count
);

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_ch (
         .clk_i        (clk_clk),
         .rst_ni       (reset_reset_n),
         .key_raw_ni   (key_raw_n[i]),
         .sticky_clr_i (sticky_clr[i]),
         .level_no     (btn_level_n[i]),
         .press_o      (btn_press[i]),
         .release_o    (btn_release[i]),
         .sticky_o     (press_sticky[i]),
         .count_o      (press_count[8*i +: 8])
      );
   end

endmodule

// File: tb/tb_push_button_conditioner.sv
// Scoreboard bench for push_button_conditioner with DEBOUNCE_CYCLES=8, NUM_BTN=4.
module tb_push_button_conditioner;

   localparam int NB  = 4;
   localparam int DC  = 8;
   localparam int LAT = 2 + DC;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [NB-1:0] key_raw_n = '0;
   logic [NB-1:0] sticky_clr = '0;
   logic [NB-1:0] btn_level_n, btn_press, btn_release, press_sticky;
   logic [8*NB-1:0] press_count;

   push_button_conditioner #(.NUM_BTN(NB), .DEBOUNCE_CYCLES(DC)) dut (
      .clk_clk       (clk),
      .reset_reset_n (rst_n),
      .key_raw_n     (key_raw_n),
      .btn_level_n   (btn_level_n),
      .btn_press     (btn_press),
      .btn_release   (btn_release),
      .press_sticky  (press_sticky),
      .sticky_clr    (sticky_clr),
      .press_count   (press_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            at;
      logic [NB-1:0] press;
      logic [NB-1:0] rel;
      logic [NB-1:0] level;
   } ev_t;

   ev_t q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_ev(input logic [NB-1:0] p, input logic [NB-1:0] r,
                            input logic [NB-1:0] lvl);
      ev_t e;
      e.at = cyc + LAT; e.press = p; e.rel = r; e.level = lvl;
      q.push_back(e);
   endtask

   // Monitor: every visible pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (rst_n && ((btn_press | btn_release) != '0)) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", {24'h0, btn_press, btn_release}, 32'h0);
         end else begin
            ev_t e;
            e = q.pop_front();
            chk("ev_cycle", cyc, e.at);
            chk("ev_press", btn_press, e.press);
            chk("ev_release", btn_release, e.rel);
            chk("ev_level", btn_level_n, e.level);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset with all keys held down.
      key_raw_n = 4'b0000;
      tick(3);
      chk("rst_level", btn_level_n, 4'hF);
      chk("rst_press", btn_press, 4'h0);
      chk("rst_release", btn_release, 4'h0);
      chk("rst_sticky", press_sticky, 4'h0);
      chk("rst_count", press_count, 32'h0);
      rst_n = 1'b1;
      expect_ev(4'hF, 4'h0, 4'h0);
      chk("post_rst_level", btn_level_n, 4'hF);
      tick(12);
      chk("all_sticky", press_sticky, 4'hF);
      key_raw_n = 4'hF;
      expect_ev(4'h0, 4'hF, 4'hF);
      tick(12);
      chk("sticky_after_release", press_sticky, 4'hF);
      sticky_clr = 4'hF;
      tick(1);
      sticky_clr = 4'h0;
      chk("sticky_cleared", press_sticky, 4'h0);
      chk("count_cleared", press_count, 32'h0);

      // Clean press on key 0.
      key_raw_n = 4'b1110;
      expect_ev(4'b0001, 4'h0, 4'b1110);
      tick(LAT);
      chk("k0_sticky", press_sticky, 4'b0001);
      tick(2);

      // Bounce on key 1: 5 low, 1 high, then low and held.
      key_raw_n = 4'b1100;
      tick(5);
      key_raw_n = 4'b1110;
      tick(1);
      key_raw_n = 4'b1100;
      expect_ev(4'b0010, 4'h0, 4'b1100);
      tick(LAT - 1);
      chk("k1_before_accept", btn_level_n, 4'b1110);
      tick(3);
      chk("k1_sticky", press_sticky, 4'b0011);

      // Press then release key 2.
      key_raw_n = 4'b1000;
      expect_ev(4'b0100, 4'h0, 4'b1000);
      tick(12);
      key_raw_n = 4'b1100;
      expect_ev(4'h0, 4'b0100, 4'b1100);
      tick(12);
      chk("k2_level", btn_level_n, 4'b1100);
      chk("k2_sticky_held", press_sticky, 4'b0111);

      // Key 3: clear in the pulse cycle loses to set; clear next cycle wins.
      key_raw_n = 4'b0100;
      expect_ev(4'b1000, 4'h0, 4'b0100);
      tick(LAT);
      sticky_clr = 4'b1000;
      tick(1);
      chk("k3_set_wins", press_sticky, 4'b1111);
      tick(1);
      sticky_clr = 4'h0;
      chk("k3_cleared", press_sticky, 4'b0111);

`ifdef BTN_PRESS_COUNT_EN
      chk("counts", press_count, 32'h0001_0101);
      key_raw_n = 4'b0101;
      expect_ev(4'h0, 4'b0001, 4'b0101);
      tick(12);
      for (int i = 0; i < 300; i++) begin
         key_raw_n = 4'b0100;
         expect_ev(4'b0001, 4'h0, 4'b0100);
         tick(12);
         key_raw_n = 4'b0101;
         expect_ev(4'h0, 4'b0001, 4'b0101);
         tick(12);
      end
      chk("count0_saturated", press_count[7:0], 8'd255);
      chk("count1_untouched", press_count[15:8], 8'd1);
      sticky_clr = 4'b0001;
      tick(1);
      sticky_clr = 4'h0;
      chk("count0_cleared", press_count[7:0], 8'd0);
`else
      chk("count_tied_zero", press_count, 32'h0);
`endif

      // Drain the scoreboard within a bounded number of cycles.
      for (int i = 0; i < 50 && q.size() != 0; i++) tick(1);
      chk("scoreboard_drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
